// File: rtl/pgm_rd.sv
// pgm_rd: replays the PGM_RAM template packet back-to-back during the test window,
// and forwards pgm_wr bypass traffic when no test is running.
module pgm_rd #(
    parameter PLATFORM = "Xilinx",
    parameter logic [7:0] LMID = 8'd63,
    parameter logic [7:0] IPG = 8'd4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1023:0] in_rd_phv,
    input  logic          in_rd_phv_wr,
    input  logic [133:0]  in_rd_data,
    input  logic          in_rd_data_wr,
    input  logic          in_rd_valid,
    input  logic          in_rd_valid_wr,
    input  logic          pgm_bypass_flag,
    input  logic          pgm_sent_start_flag,
    input  logic          pgm_sent_finish_flag,
    output logic          rd2ram_rd_en,
    output logic [6:0]    rd2ram_addr,
    input  logic [143:0]  ram2rd_rdata,
    output logic [1023:0] out_rd_phv,
    output logic          out_rd_phv_wr,
    output logic [133:0]  out_rd_data,
    output logic          out_rd_data_wr,
    output logic          out_rd_valid,
    output logic          out_rd_valid_wr,
    input  logic          in_rd_alf,
    output logic [31:0]   out_rd_pkt_cnt,
    output logic [31:0]   out_rd_drop_cnt,
    output logic          out_rd_err
);
    typedef enum logic [1:0] {IDLE_S, BYPASS_S, GEN_S, GAP_S} state_t;
    state_t state, state_n;
    logic start_q, stop_req, rd_en_q, restart, clr;
    logic [6:0] raddr_q;
    logic [7:0] gap_cnt;
    logic [1:0] hdr;
    logic start_rise, in_tail, fwd, drop, qual, first_w, bad_head, last_w, forced, tail_w;
    logic gap_ready, halt, unused_ok;
    logic [133:0] word;

    assign unused_ok  = ^{ram2rd_rdata[143:134], LMID, PLATFORM == "Xilinx"};
    assign hdr        = ram2rd_rdata[133:132];
    assign start_rise = pgm_sent_start_flag & ~start_q;
    assign in_tail    = in_rd_data[133:132] == 2'b10;
    assign fwd        = in_rd_data_wr & ((state == BYPASS_S) | ((state == IDLE_S) & ~start_rise
                        & pgm_bypass_flag & (in_rd_data[133:132] == 2'b01)));
    assign drop       = in_rd_data_wr & ((state == GEN_S) | (state == GAP_S));
    // rd_en_q is cleared when a packet ends, so the speculative read never qualifies
    assign qual       = rd_en_q & (state == GEN_S);
    assign first_w    = qual & (raddr_q == 7'd0);
    assign bad_head   = first_w & (hdr != 2'b01);
    assign last_w     = qual & (raddr_q == 7'd127);
    assign forced     = last_w & (hdr != 2'b10);
    assign tail_w     = qual & ~bad_head & ((hdr == 2'b10) | last_w);
    assign word       = forced ? {2'b10, ram2rd_rdata[131:0]} : ram2rd_rdata[133:0];
    assign gap_ready  = (IPG == 8'd0) | (gap_cnt >= IPG - 8'd1);
    assign halt       = stop_req | pgm_sent_finish_flag | ~pgm_sent_start_flag;
    assign clr        = (state == IDLE_S) & start_rise;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE_S;
        else state <= state_n;

    always_comb begin
        state_n = state;
        restart = 1'b0;
        case (state)
            IDLE_S: begin
                restart = start_rise;
                state_n = start_rise ? GEN_S : fwd ? BYPASS_S : IDLE_S;
            end
            BYPASS_S: state_n = (in_rd_data_wr & in_tail) ? IDLE_S : BYPASS_S;
            GEN_S: begin
                restart = tail_w & (IPG == 8'd0) & ~halt & ~in_rd_alf;
                state_n = bad_head ? IDLE_S : ~tail_w ? GEN_S : (IPG != 8'd0) ? GAP_S :
                          halt ? IDLE_S : in_rd_alf ? GAP_S : GEN_S;
            end
            default: begin
                restart = gap_ready & ~halt & ~in_rd_alf;
                state_n = ~gap_ready ? GAP_S : halt ? IDLE_S : in_rd_alf ? GAP_S : GEN_S;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q      <= 1'b0;
            stop_req     <= 1'b0;
            rd_en_q      <= 1'b0;
            raddr_q      <= 7'd0;
            gap_cnt      <= 8'd0;
            rd2ram_rd_en <= 1'b0;
            rd2ram_addr  <= 7'd0;
        end else begin
            start_q      <= pgm_sent_start_flag;
            stop_req     <= pgm_sent_finish_flag | (stop_req & ~clr);
            rd_en_q      <= rd2ram_rd_en & ~bad_head & ~tail_w;
            raddr_q      <= rd2ram_addr;
            gap_cnt      <= ((state == GAP_S) & (state_n == GAP_S)) ? gap_cnt + {7'd0, gap_cnt != 8'hFF} : 8'd0;
            rd2ram_rd_en <= state_n == GEN_S;
            rd2ram_addr  <= ((state_n == GEN_S) & ~restart) ? rd2ram_addr + 7'd1 : 7'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rd_phv      <= '0;
            out_rd_phv_wr   <= 1'b0;
            out_rd_data     <= '0;
            out_rd_data_wr  <= 1'b0;
            out_rd_valid    <= 1'b0;
            out_rd_valid_wr <= 1'b0;
            out_rd_pkt_cnt  <= 32'd0;
            out_rd_drop_cnt <= 32'd0;
            out_rd_err      <= 1'b0;
        end else begin
            out_rd_data     <= fwd ? in_rd_data : (qual & ~bad_head) ? word : '0;
            out_rd_data_wr  <= fwd | (qual & ~bad_head);
            out_rd_phv      <= fwd ? in_rd_phv : '0;
            out_rd_phv_wr   <= fwd ? in_rd_phv_wr : first_w & ~bad_head;
            out_rd_valid    <= fwd ? in_rd_valid | in_tail : tail_w;
            out_rd_valid_wr <= fwd ? in_rd_valid_wr | in_tail : tail_w;
            out_rd_pkt_cnt  <= clr ? 32'd0 : out_rd_pkt_cnt + {31'd0, tail_w & ~&out_rd_pkt_cnt};
            out_rd_drop_cnt <= clr ? 32'd0 : out_rd_drop_cnt + {31'd0, drop & ~&out_rd_drop_cnt};
            out_rd_err      <= ~clr & (out_rd_err | bad_head | forced);
        end
    end
endmodule
